obstacle_gen: RTL and testbench

OBSTACLE_GEN -- requirements
Module: obstacle_gen

---
 rtl/obstacle_gen.sv | 206 ++++++++++++++++++++
 tb/tb_obstacle_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_gen.sv
// obstacle_gen: LFSR-driven obstacle column generator feeding a show-ahead FIFO.
// Define OBSTACLE_GEN_SCORE_EN to build the saturating popped-pipe counter.
module obstacle_gen #(
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [15:0]            seed,
    input  logic                   req,
    output logic [1:0]             obs,
    output logic                   obs_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underflow,
    output logic [7:0]             pipes_popped
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int GW = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);

    localparam logic [15:0]   LFSR_INIT  = 16'hACE1;
    localparam logic [15:0]   LFSR_MASK  = 16'hB400;
    localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO   = PW'(0);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [GW-1:0] GAP_ZERO   = GW'(0);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_GAP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ({1'b0, v[15:1]} ^ LFSR_MASK) : {1'b0, v[15:1]};
    endfunction

    state_t          state_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic [GW-1:0]   gap_r;
    logic [15:0]     lfsr_r;
    logic            underflow_r;
    logic [1:0]      obs_r;
    logic            obs_valid_r;
    logic [1:0]      mem_r [DEPTH];

    state_t          state_next_s;
    logic            push_s;
    logic            pop_s;
    logic            uflow_s;
    logic [1:0]      push_data_s;
    logic [GW-1:0]   gap_next_s;
    logic [PW-1:0]   wr_next_s;
    logic [PW-1:0]   rd_next_s;
    logic [LW-1:0]   level_next_s;
    logic [1:0]      head_next_s;
    logic            valid_next_s;

    // Next-state, FIFO bookkeeping and look-ahead of the registered head column
    always_comb begin
        push_s = !start && (state_r == ST_FILL || state_r == ST_RUN) && (level_r < LEVEL_FULL);
        pop_s  = !start && req && obs_valid_r;
        uflow_s = !start && req && (state_r == ST_RUN) && !obs_valid_r;

        push_data_s = (gap_r != GAP_ZERO) ? 2'b00 : lfsr_r[1:0];
        if (gap_r != GAP_ZERO) begin
            gap_next_s = gap_r - GAP_ONE;
        end else if (lfsr_r[1:0] != 2'b00) begin
            gap_next_s = GAP_RELOAD;
        end else begin
            gap_next_s = gap_r;
        end

        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = ST_IDLE;
            ST_FILL: state_next_s = (level_r == LEVEL_FULL) ? ST_RUN : ST_FILL;
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_IDLE;
        endcase
        if (start) begin
            state_next_s = ST_FILL;
        end else begin
            state_next_s = state_next_s;
        end

        wr_next_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_next_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        if (push_s && !pop_s) begin
            level_next_s = level_r + LEVEL_ONE;
        end else if (pop_s && !push_s) begin
            level_next_s = level_r - LEVEL_ONE;
        end else begin
            level_next_s = level_r;
        end
        if (start) begin
            wr_next_s    = PTR_ZERO;
            rd_next_s    = PTR_ZERO;
            level_next_s = LEVEL_ZERO;
        end else begin
            level_next_s = level_next_s;
        end

        // A push landing on the new head slot only happens when it becomes the sole entry
        if (level_next_s == LEVEL_ZERO) begin
            head_next_s = 2'b00;
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end

        valid_next_s = (state_next_s == ST_RUN) && (level_next_s != LEVEL_ZERO);
    end

    // Control state, LFSR, gap counter and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LEVEL_ZERO;
            gap_r       <= GAP_ZERO;
            lfsr_r      <= LFSR_INIT;
            underflow_r <= 1'b0;
            obs_r       <= 2'b00;
            obs_valid_r <= 1'b0;
        end else if (start) begin
            state_r     <= ST_FILL;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LEVEL_ZERO;
            gap_r       <= GAP_ZERO;
            lfsr_r      <= (seed == 16'h0000) ? LFSR_INIT : seed;
            underflow_r <= 1'b0;
            obs_r       <= 2'b00;
            obs_valid_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            level_r  <= level_next_s;
            if (push_s) begin
                gap_r  <= gap_next_s;
                lfsr_r <= lfsr_step(lfsr_r);
            end else begin
                gap_r  <= gap_r;
                lfsr_r <= lfsr_r;
            end
            if (uflow_s) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
            obs_r       <= head_next_s;
            obs_valid_r <= valid_next_s;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 2'b00;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

`ifdef OBSTACLE_GEN_SCORE_EN
    logic [7:0] popped_r;

    // Saturating count of popped pipe columns
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            popped_r <= 8'h00;
        end else if (start) begin
            popped_r <= 8'h00;
        end else if (pop_s && (obs_r != 2'b00) && (popped_r != 8'hFF)) begin
            popped_r <= popped_r + 8'h01;
        end else begin
            popped_r <= popped_r;
        end
    end

    assign pipes_popped = popped_r;
`else
    assign pipes_popped = 8'h00;
`endif

    assign obs       = obs_r;
    assign obs_valid = obs_valid_r;
    assign level     = level_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_obstacle_gen.sv
// tb_obstacle_gen: random and directed stimulus checked cycle by cycle against
// a queue-based reference model of the obstacle generator.
module tb_obstacle_gen;
    localparam int DEPTH   = 4;
    localparam int MIN_GAP = 3;
    localparam int LW      = $clog2(DEPTH) + 1;
`ifdef OBSTACLE_GEN_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [15:0]   seed;
    logic          req;
    logic [1:0]    obs;
    logic          obs_valid;
    logic [LW-1:0] level;
    logic          underflow;
    logic [7:0]    pipes_popped;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model: 0 idle, 1 fill, 2 run
    int m_mode;
    int m_q[$];
    int m_gap;
    int m_lfsr;
    bit m_uf;
    int m_cnt;
    int zeros_since_pipe;

    obstacle_gen #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .seed         (seed),
        .req          (req),
        .obs          (obs),
        .obs_valid    (obs_valid),
        .level        (level),
        .underflow    (underflow),
        .pipes_popped (pipes_popped)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic m_reset();
        m_mode = 0;
        m_q.delete();
        m_gap  = 0;
        m_lfsr = 'hACE1;
        m_uf   = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic m_step(input bit s, input int sd, input bit r);
        bit valid;
        bit gen;
        int next_mode;
        int head;
        int v;
        if (s) begin
            m_q.delete();
            m_gap  = 0;
            m_uf   = 1'b0;
            m_cnt  = 0;
            m_lfsr = (sd == 0) ? 'hACE1 : sd;
            m_mode = 1;
            return;
        end
        valid     = (m_mode == 2) && (m_q.size() > 0);
        gen       = (m_mode != 0) && (m_q.size() < DEPTH);
        next_mode = (m_mode == 1 && m_q.size() == DEPTH) ? 2 : m_mode;
        if (r && m_mode == 2 && !valid) m_uf = 1'b1;
        if (r && valid) begin
            head = m_q.pop_front();
            if (SCORE_ON && head != 0 && m_cnt < 255) m_cnt++;
        end
        if (gen) begin
            if (m_gap > 0) begin
                m_q.push_back(0);
                m_gap--;
            end else begin
                v = m_lfsr % 4;
                m_q.push_back(v);
                if (v != 0) m_gap = MIN_GAP;
            end
            m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
        end
        m_mode = next_mode;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".obs"}, int'(obs), (m_q.size() > 0) ? m_q[0] : 0);
        check_val({tag, ".obs_valid"}, int'(obs_valid), int'(m_mode == 2 && m_q.size() > 0));
        check_val({tag, ".level"}, int'(level), m_q.size());
        check_val({tag, ".underflow"}, int'(underflow), int'(m_uf));
        check_val({tag, ".pipes_popped"}, int'(pipes_popped), m_cnt);
    endtask

    task automatic drive_cycle(input bit s, input logic [15:0] sd, input bit r, input string tag);
        start = s;
        seed  = sd;
        req   = r;
        if (s) begin
            zeros_since_pipe = -1;
        end else if (r && obs_valid) begin
            if (obs != 2'b00) begin
                if (zeros_since_pipe >= 0)
                    check_val({tag, ".gap"}, int'(zeros_since_pipe >= MIN_GAP), 1);
                zeros_since_pipe = 0;
            end else if (zeros_since_pipe >= 0) begin
                zeros_since_pipe++;
            end
        end
        @(posedge clk);
        #1;
        m_step(s, int'(sd), r);
        check_outputs(tag);
    endtask

    initial begin
        int lat;
        bit found;
        logic [1:0] exp_seq [4];
        exp_seq = '{2'b01, 2'b00, 2'b00, 2'b00};
        zeros_since_pipe = -1;
        resetn = 1'b0;
        start  = 1'b0;
        req    = 1'b0;
        seed   = 16'h0000;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // req in IDLE is ignored
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 16'h0000, 1'b1, "idle_req");
        check_val("idle.level", int'(level), 0);
        check_val("idle.underflow", int'(underflow), 0);

        // seed 1: fill latency and first four columns
        drive_cycle(1'b1, 16'h0001, 1'b0, "start1");
        lat = 0;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            drive_cycle(1'b0, 16'h0000, 1'b0, "fill1");
            if (obs_valid) begin
                found = 1'b1;
                lat = k;
            end
        end
        check_val("latency", lat, DEPTH + 1);
        for (int i = 0; i < 4; i++) begin
            check_val("seq1", int'(obs), int'(exp_seq[i]));
            drive_cycle(1'b0, 16'h0000, 1'b1, "pop1");
        end

        // seed 0 falls back to ACE1, first entry 01
        drive_cycle(1'b1, 16'h0000, 1'b0, "start0");
        drive_cycle(1'b0, 16'h0000, 1'b0, "first0");
        check_val("seed0.obs", int'(obs), 1);
        check_val("seed0.level", int'(level), 1);

        // random traffic with occasional restarts
        for (int i = 0; i < 800; i++) begin
            drive_cycle(($urandom_range(0, 99) == 0), 16'($urandom_range(0, 65535)),
                        1'($urandom_range(0, 1)), "rand");
        end

        // start together with req while full in RUN
        drive_cycle(1'b1, 16'h5A5A, 1'b0, "start2");
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 16'h0000, 1'b0, "fill2");
        for (int i = 0; i < 12; i++) drive_cycle(1'b0, 16'h0000, 1'b1, "pop2");
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 16'h0000, 1'b0, "refill2");
        check_val("full.level", int'(level), DEPTH);
        drive_cycle(1'b1, 16'h1111, 1'b1, "start_req");
        check_val("start_req.level", int'(level), 0);
        check_val("start_req.underflow", int'(underflow), 0);
        check_val("start_req.pipes", int'(pipes_popped), 0);

        // long pop run for counter saturation
        drive_cycle(1'b1, 16'h1234, 1'b0, "start3");
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 16'h0000, 1'b0, "fill3");
        for (int i = 0; i < 3000; i++) drive_cycle(1'b0, 16'h0000, 1'b1, "sat");
        check_val("sat.final", int'(pipes_popped), SCORE_ON ? 255 : 0);

        // asynchronous reset mid-operation
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        m_reset();
        zeros_since_pipe = -1;
        check_outputs("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0000, 1'b1, "post_rst");
        check_val("post_rst.level", int'(level), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
